echo_correlation: RTL and testbench

- Matched-filter echo detector for the ultrasound receive path.
- After a start pulse it drains 12-bit ADC samples from an upstream normal-mode FIFO (the codebase's `fifo`, rdreq→q latency 1) at one sample per clock.
- Correlates a sliding window against a fixed ±1 transmit template and reports time-of-flight (sample index) and magnitude of the strongest above-threshold correlation.

---
 rtl/echo_corr_pkg.sv | 35 +++
 rtl/echo_corr_mac.sv | 76 +++++++
 rtl/echo_correlation.sv | 167 ++++++++++++++++
 tb/tb_echo_correlation.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/echo_corr_pkg.sv
// Shared widths, default template and types for the echo correlation detector.
package echo_corr_pkg;

    localparam int unsigned SAMPLE_W     = 12;
    localparam int unsigned CORR_W       = 18;
    localparam int unsigned IDX_W        = 20;
    localparam int unsigned X_W          = SAMPLE_W + 1;
    localparam int unsigned SUM_W        = CORR_W + 1;
    localparam int unsigned ADC_MID      = 2048;
    localparam int unsigned MAX_TAPS     = 32;
    localparam int unsigned FLUSH_CYCLES = 3;

    localparam logic [MAX_TAPS-1:0] DEFAULT_COEF = 32'h0000_F0F0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FLUSH,
        ST_DONE
    } state_t;

    // Per-sample side information travelling alongside the data pipeline.
    typedef struct packed {
        logic             elig;
        logic [IDX_W-1:0] idx;
    } samp_tag_t;

    // Absolute value of the correlation sum, clipped to the output width.
    function automatic logic [CORR_W-1:0] sat_mag(input logic signed [SUM_W-1:0] s);
        logic [SUM_W-1:0] a;
        a = s[SUM_W-1] ? SUM_W'(-s) : SUM_W'(s);
        return a[SUM_W-1] ? {CORR_W{1'b1}} : a[CORR_W-1:0];
    endfunction

endpackage

// File: rtl/echo_corr_mac.sv
// Sliding sample window and registered +/-1 template correlator.
// Stage 1 registers the centred sample into the window, stage 2 registers the sum.
module echo_corr_mac
    import echo_corr_pkg::*;
#(
    parameter int unsigned          TAPS = 16,
    parameter logic [MAX_TAPS-1:0]  COEF = DEFAULT_COEF
) (
    input  logic                     clk_50M,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     in_valid,
    input  logic [SAMPLE_W-1:0]      sample,
    input  samp_tag_t                in_tag,
    output logic                     sum_valid,
    output logic signed [SUM_W-1:0]  sum,
    output samp_tag_t                sum_tag
);

    logic [TAPS-1:0][X_W-1:0] win;
    logic                     win_valid;
    samp_tag_t                win_tag;
    logic [X_W-1:0]           x_c;
    logic signed [SUM_W-1:0]  acc_c;

    // Offset-binary to two's complement; wraps correctly in X_W bits.
    assign x_c = {1'b0, sample} - X_W'(ADC_MID);

    // Stage 1: slot 0 holds the newest sample.
    always_ff @(posedge clk_50M or posedge rst_n) begin
        if (rst_n) begin
            win       <= '0;
            win_valid <= 1'b0;
            win_tag   <= '0;
        end else if (clr) begin
            win       <= '0;
            win_valid <= 1'b0;
            win_tag   <= '0;
        end else begin
            win_valid <= in_valid;
            win_tag   <= in_tag;
            if (in_valid) begin
                win <= {win[TAPS-2:0], x_c};
            end
        end
    end

    always_comb begin
        acc_c = '0;
        for (int unsigned i = 0; i < TAPS; i++) begin
            if (COEF[i]) begin
                acc_c = acc_c + SUM_W'($signed(win[i]));
            end else begin
                acc_c = acc_c - SUM_W'($signed(win[i]));
            end
        end
    end

    // Stage 2: registered correlation sum.
    always_ff @(posedge clk_50M or posedge rst_n) begin
        if (rst_n) begin
            sum_valid <= 1'b0;
            sum       <= '0;
            sum_tag   <= '0;
        end else if (clr) begin
            sum_valid <= 1'b0;
            sum       <= '0;
            sum_tag   <= '0;
        end else begin
            sum_valid <= win_valid;
            sum       <= acc_c;
            sum_tag   <= win_tag;
        end
    end

endmodule

// File: rtl/echo_correlation.sv
// Matched-filter echo detector: drains the ADC FIFO, correlates and tracks the peak.
// Optional ECHO_BLANKING_EN makes the first BLANK_SAMPLES samples ineligible for detection.
module echo_correlation
    import echo_corr_pkg::*;
#(
    parameter int unsigned          TAPS          = 16,
    parameter logic [MAX_TAPS-1:0]  COEF          = DEFAULT_COEF,
    parameter int unsigned          MAX_SAMPLES   = 10000,
    parameter int unsigned          EMPTY_TIMEOUT = 64
`ifdef ECHO_BLANKING_EN
    ,
    parameter int unsigned          BLANK_SAMPLES = 64
`endif
) (
    input  logic                 clk_50M,
    input  logic                 rst_n,
    input  logic                 sys_start_pulse,
    input  logic [SAMPLE_W-1:0]  fifo_q,
    input  logic                 fifo_empty,
    output logic                 fifo_rdreq,
    input  logic [CORR_W-1:0]    corr_threshold,
    output logic [IDX_W-1:0]     echo_tof,
    output logic [CORR_W-1:0]    echo_peak,
    output logic                 hit_flag,
    output logic                 processing_done
);

    localparam int unsigned ET_W     = $clog2(EMPTY_TIMEOUT + 1);
    localparam int unsigned FL_W     = 2;
    localparam int unsigned WARM_IDX = TAPS - 1;
`ifdef ECHO_BLANKING_EN
    localparam int unsigned ELIG_IDX = (BLANK_SAMPLES > WARM_IDX) ? BLANK_SAMPLES : WARM_IDX;
`else
    localparam int unsigned ELIG_IDX = WARM_IDX;
`endif

    state_t                  state;
    state_t                  state_nxt;
    logic [IDX_W-1:0]        rd_cnt;
    logic [ET_W-1:0]         empty_cnt;
    logic [FL_W-1:0]         flush_cnt;
    logic                    last_read_c;
    logic                    timeout_c;
    samp_tag_t               rd_tag_c;
    logic                    rd_d1;
    samp_tag_t               tag_d1;
    logic                    sum_valid;
    logic signed [SUM_W-1:0] sum;
    samp_tag_t               sum_tag;
    logic [CORR_W-1:0]       mag_c;

    always_ff @(posedge clk_50M or posedge rst_n) begin
        if (rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (sys_start_pulse) begin
            state_nxt = ST_RUN;
        end else begin
            case (state)
                ST_IDLE:  state_nxt = ST_IDLE;
                ST_RUN:   if (last_read_c || timeout_c) state_nxt = ST_FLUSH;
                ST_FLUSH: if (flush_cnt == FL_W'(FLUSH_CYCLES - 1)) state_nxt = ST_DONE;
                ST_DONE:  state_nxt = ST_DONE;
                default:  state_nxt = ST_IDLE;
            endcase
        end
    end

    // Reads follow the FIFO flag directly so a non-empty FIFO drains at one sample per clock.
    always_comb begin
        fifo_rdreq  = 1'b0;
        last_read_c = 1'b0;
        timeout_c   = 1'b0;
        if (state == ST_RUN) begin
            fifo_rdreq  = !fifo_empty;
            last_read_c = !fifo_empty && (rd_cnt == IDX_W'(MAX_SAMPLES - 1));
            timeout_c   = fifo_empty && (empty_cnt == ET_W'(EMPTY_TIMEOUT - 1));
        end
    end

    always_ff @(posedge clk_50M or posedge rst_n) begin
        if (rst_n) begin
            rd_cnt    <= '0;
            empty_cnt <= '0;
            flush_cnt <= '0;
        end else if (sys_start_pulse) begin
            rd_cnt    <= '0;
            empty_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (fifo_rdreq) begin
                rd_cnt <= rd_cnt + 1'b1;
            end
            if ((state == ST_RUN) && fifo_empty) begin
                empty_cnt <= empty_cnt + 1'b1;
            end else begin
                empty_cnt <= '0;
            end
            flush_cnt <= (state == ST_FLUSH) ? flush_cnt + 1'b1 : '0;
        end
    end

    assign rd_tag_c.elig = (rd_cnt >= IDX_W'(ELIG_IDX));
    assign rd_tag_c.idx  = rd_cnt;

    // Read strobe and index aligned with the FIFO data arriving one cycle later.
    always_ff @(posedge clk_50M or posedge rst_n) begin
        if (rst_n) begin
            rd_d1  <= 1'b0;
            tag_d1 <= '0;
        end else if (sys_start_pulse) begin
            rd_d1  <= 1'b0;
            tag_d1 <= '0;
        end else begin
            rd_d1  <= fifo_rdreq;
            tag_d1 <= rd_tag_c;
        end
    end

    echo_corr_mac #(
        .TAPS (TAPS),
        .COEF (COEF)
    ) u_mac (
        .clk_50M   (clk_50M),
        .rst_n     (rst_n),
        .clr       (sys_start_pulse),
        .in_valid  (rd_d1),
        .sample    (fifo_q),
        .in_tag    (tag_d1),
        .sum_valid (sum_valid),
        .sum       (sum),
        .sum_tag   (sum_tag)
    );

    assign mag_c = sat_mag(sum);

    // Stage 3: peak tracker; strict '>' keeps the earliest index on ties.
    always_ff @(posedge clk_50M or posedge rst_n) begin
        if (rst_n) begin
            echo_tof        <= '0;
            echo_peak       <= '0;
            hit_flag        <= 1'b0;
            processing_done <= 1'b0;
        end else if (sys_start_pulse) begin
            echo_tof        <= '0;
            echo_peak       <= '0;
            hit_flag        <= 1'b0;
            processing_done <= 1'b0;
        end else begin
            processing_done <= (state_nxt == ST_DONE);
            if (sum_valid && sum_tag.elig && (mag_c >= corr_threshold)) begin
                hit_flag <= 1'b1;
                if (mag_c > echo_peak) begin
                    echo_peak <= mag_c;
                    echo_tof  <= sum_tag.idx;
                end
            end
        end
    end

endmodule

// File: tb/tb_echo_correlation.sv
// Self-checking bench for echo_correlation: FIFO model, reference correlator and scoreboard.
`timescale 1ns/1ps
module tb_echo_correlation;

    localparam int TAPS     = 16;
    localparam int MAXS     = 10000;
    localparam int EMPTY_TO = 64;
    localparam int FLUSH    = 3;
    localparam int BLANK    = 64;
    localparam int BUDGET   = 12000;
    localparam int MEMN     = 10016;
    localparam logic [15:0] TB_COEF = 16'b1111_0000_1111_0000;

    typedef struct {
        string        name;
        int           n;
        int           b1_end;
        int           b1_amp;
        int           b2_end;
        int           b2_amp;
        logic [17:0]  thr;
        logic         exp_hit;
        int           exp_tof;
    } vec_t;

    typedef struct {
        logic hit;
        int   peak;
        int   tof;
        int   reads;
        int   lat;
    } exp_t;

    logic        clk_50M = 1'b0;
    logic        rst_n;
    logic        sys_start_pulse;
    logic [11:0] fifo_q;
    logic        fifo_empty;
    logic        fifo_rdreq;
    logic [17:0] corr_threshold;
    logic [19:0] echo_tof;
    logic [17:0] echo_peak;
    logic        hit_flag;
    logic        processing_done;

    logic [11:0] mem [MEMN];
    logic [15:0] coef_v;
    int          wr_cnt, rd_ptr;
    int          cyc, last_rd_cyc, done_cyc, n_reads, bubbles, bad_rd;
    logic        running;
    int          total, bad;
    exp_t        exp_q [$];
    vec_t        vecs [9];

    echo_correlation dut (
        .clk_50M         (clk_50M),
        .rst_n           (rst_n),
        .sys_start_pulse (sys_start_pulse),
        .fifo_q          (fifo_q),
        .fifo_empty      (fifo_empty),
        .fifo_rdreq      (fifo_rdreq),
        .corr_threshold  (corr_threshold),
        .echo_tof        (echo_tof),
        .echo_peak       (echo_peak),
        .hit_flag        (hit_flag),
        .processing_done (processing_done)
    );

    always #10 clk_50M = ~clk_50M;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // One clock: observe at negedge, then model the FIFO's registered read port.
    task automatic step();
        logic rd_s;
        @(negedge clk_50M);
        cyc++;
        rd_s = fifo_rdreq;
        if (running && !fifo_empty && !fifo_rdreq && !processing_done) bubbles++;
        if (fifo_rdreq && fifo_empty) bad_rd++;
        if (fifo_rdreq) begin
            last_rd_cyc = cyc;
            n_reads++;
        end
        if (processing_done && done_cyc < 0) done_cyc = cyc;
        @(posedge clk_50M);
        #1;
        if (rd_s && rd_ptr < MEMN) begin
            fifo_q = mem[rd_ptr];
            rd_ptr++;
        end
        fifo_empty = (rd_ptr >= wr_cnt);
    endtask

    task automatic put_burst(input int e, input int a);
        for (int j = 0; j < TAPS; j++) begin
            mem[e-j] = coef_v[j] ? 12'(2048 + a) : 12'(2047 - a);
        end
    endtask

    task automatic load(input vec_t v);
        for (int k = 0; k < v.n; k++) mem[k] = 12'd2048;
        if (v.b1_end >= 0) put_burst(v.b1_end, v.b1_amp);
        if (v.b2_end >= 0) put_burst(v.b2_end, v.b2_amp);
        wr_cnt     = v.n;
        rd_ptr     = 0;
        fifo_empty = (v.n == 0);
    endtask

    // Direct correlation over the loaded samples, index by index.
    function automatic exp_t model(input int n, input logic [17:0] thr);
        exp_t e;
        int   nr;
        e.hit = 1'b0; e.peak = 0; e.tof = 0;
        nr = (n < MAXS) ? n : MAXS;
        e.reads = nr;
        e.lat   = (n >= MAXS) ? FLUSH + 1 : EMPTY_TO + FLUSH + 1;
        for (int k = TAPS - 1; k < nr; k++) begin
            int c, m, x;
            logic ok;
            c = 0;
            for (int i = 0; i < TAPS; i++) begin
                x = int'(mem[k-i]) - 2048;
                c = coef_v[i] ? c + x : c - x;
            end
            m = (c < 0) ? -c : c;
            if (m > 262143) m = 262143;
`ifdef ECHO_BLANKING_EN
            ok = (k >= BLANK);
`else
            ok = 1'b1;
`endif
            if (ok && m >= int'(thr)) begin
                e.hit = 1'b1;
                if (m > e.peak) begin
                    e.peak = m;
                    e.tof  = k;
                end
            end
        end
        return e;
    endfunction

    task automatic run_vec(input vec_t v);
        exp_t g;
        load(v);
        exp_q.push_back(model(v.n, v.thr));
        corr_threshold  = v.thr;
        sys_start_pulse = 1'b1;
        step();
        sys_start_pulse = 1'b0;
        chk({v.name, ".clr_done"}, 32'(processing_done), 0);
        chk({v.name, ".clr_peak"}, 32'(echo_peak) + 32'(echo_tof) + 32'(hit_flag), 0);
        n_reads  = 0;
        bubbles  = 0;
        bad_rd   = 0;
        done_cyc = -1;
        running  = 1'b1;
        for (int c = 0; c < BUDGET; c++) begin
            step();
            if (done_cyc >= 0) break;
        end
        running = 1'b0;
        g = exp_q.pop_front();
        if (done_cyc < 0) begin
            total++;
            bad++;
            $display("FAIL %s.timeout: no processing_done within %0d cycles", v.name, BUDGET);
        end else begin
            chk({v.name, ".hit"},      32'(hit_flag),  32'(g.hit));
            chk({v.name, ".peak"},     32'(echo_peak), g.peak);
            chk({v.name, ".tof"},      32'(echo_tof),  g.tof);
            chk({v.name, ".tbl_hit"},  32'(hit_flag),  32'(v.exp_hit));
            chk({v.name, ".tbl_tof"},  32'(echo_tof),  v.exp_tof);
            chk({v.name, ".tof_lt_n"}, 32'(int'(echo_tof) < v.n), 1);
            chk({v.name, ".reads"},    n_reads, g.reads);
            chk({v.name, ".latency"},  done_cyc - last_rd_cyc, g.lat);
            chk({v.name, ".bubbles"},  bubbles, 0);
            chk({v.name, ".rd_empty"}, bad_rd, 0);
            repeat (5) step();
            chk({v.name, ".done_hold"}, 32'(processing_done), 1);
        end
    endtask

    initial begin
        vec_t rv;
        total = 0; bad = 0; cyc = 0; running = 1'b0;
        n_reads = 0; bubbles = 0; bad_rd = 0; done_cyc = -1; last_rd_cyc = 0;
        coef_v = TB_COEF;
        wr_cnt = 0; rd_ptr = 0;
        fifo_q = '0; fifo_empty = 1'b1; sys_start_pulse = 1'b0; corr_threshold = 18'd4500;

        vecs[0] = '{"flat",      10000, -1,    0,    -1,   0,    18'd4500,  1'b0, 0};
        vecs[1] = '{"single",    10000, 5000,  2047, -1,   0,    18'd4500,  1'b1, 5000};
        vecs[2] = '{"tie",       10000, 3000,  2047, 7000, 2047, 18'd4500,  1'b1, 3000};
        vecs[3] = '{"larger2",   10000, 3000,  1023, 7000, 2047, 18'd4500,  1'b1, 7000};
        vecs[4] = '{"short",     500,   300,   2047, -1,   0,    18'd4500,  1'b1, 300};
        vecs[5] = '{"thr_eq",    200,   100,   2047, -1,   0,    18'd32760, 1'b1, 100};
        vecs[6] = '{"thr_above", 200,   100,   2047, -1,   0,    18'd32761, 1'b0, 0};
`ifdef ECHO_BLANKING_EN
        vecs[7] = '{"warmup",    200,   15,    2047, -1,   0,    18'd4500,  1'b0, 0};
        vecs[8] = '{"blank40",   200,   40,    2047, -1,   0,    18'd4500,  1'b0, 0};
`else
        vecs[7] = '{"warmup",    200,   15,    2047, -1,   0,    18'd4500,  1'b1, 15};
        vecs[8] = '{"blank40",   200,   40,    2047, -1,   0,    18'd4500,  1'b1, 40};
`endif

        // Reset values, then a reset landing in the middle of an acquisition.
        rst_n = 1'b1;
        #1;
        chk("rst.outputs", 32'(echo_peak) + 32'(echo_tof) + 32'(hit_flag) + 32'(processing_done), 0);
        rv = '{"rst", 50, 16, 2047, -1, 0, 18'd4500, 1'b1, 16};
        load(rv);
        repeat (3) step();
        chk("rst.rdreq_held", 32'(fifo_rdreq), 0);
        rst_n = 1'b0;
        repeat (2) step();
        chk("idle.rdreq", 32'(fifo_rdreq), 0);
        chk("idle.done",  32'(processing_done), 0);
        sys_start_pulse = 1'b1;
        step();
        sys_start_pulse = 1'b0;
        repeat (24) step();
        chk("run.rdreq",  32'(fifo_rdreq), 1);
        chk("run.hit",    32'(hit_flag), 1);
        rst_n = 1'b1;
        #1;
        chk("midrst.rdreq",   32'(fifo_rdreq), 0);
        chk("midrst.outputs", 32'(echo_peak) + 32'(echo_tof) + 32'(hit_flag) + 32'(processing_done), 0);
        repeat (3) step();
        rst_n = 1'b0;
        repeat (2) step();
        chk("postrst.rdreq", 32'(fifo_rdreq), 0);

        for (int i = 0; i < 9; i++) begin
            run_vec(vecs[i]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
